// File: rtl/mult_bist_pkg.sv
// rtl/mult_bist_pkg.sv - shared types and constants for the multiplier self-test engine
package mult_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h100B;
    localparam logic [15:0] MISR_INIT = 16'hFFFF;
    localparam logic [7:0]  ERR_MAX   = 8'd255;

    function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ d;
    endfunction

endpackage

// File: rtl/mbist_delay.sv
// rtl/mbist_delay.sv - LAT-stage delay line carrying {valid, a, b, expected}; wire-through when LAT=0
module mbist_delay #(
    parameter int WIDTH = 4,
    parameter int LAT   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2*WIDTH-1:0] in_exp,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_a,
    output logic [WIDTH-1:0]   out_b,
    output logic [2*WIDTH-1:0] out_exp
);

    if (LAT == 0) begin : g_bypass
        wire unused_bypass = ^{clk, rst, clr};
        assign out_valid = in_valid;
        assign out_a     = in_a;
        assign out_b     = in_b;
        assign out_exp   = in_exp;
    end else begin : g_pipe
        logic               valid_q [LAT];
        logic [WIDTH-1:0]   a_q     [LAT];
        logic [WIDTH-1:0]   b_q     [LAT];
        logic [2*WIDTH-1:0] exp_q   [LAT];

        // Only the valid bits need clearing; payload is ignored while invalid.
        always_ff @(posedge clk) begin
            for (int i = 0; i < LAT; i++) begin
                if (rst || clr) begin
                    valid_q[i] <= 1'b0;
                end else begin
                    valid_q[i] <= (i == 0) ? in_valid : valid_q[(i == 0) ? 0 : i-1];
                end
                a_q[i]   <= (i == 0) ? in_a   : a_q[(i == 0) ? 0 : i-1];
                b_q[i]   <= (i == 0) ? in_b   : b_q[(i == 0) ? 0 : i-1];
                exp_q[i] <= (i == 0) ? in_exp : exp_q[(i == 0) ? 0 : i-1];
            end
        end

        assign out_valid = valid_q[LAT-1];
        assign out_a     = a_q[LAT-1];
        assign out_b     = b_q[LAT-1];
        assign out_exp   = exp_q[LAT-1];
    end

endmodule

// File: rtl/mult_bist.sv
// rtl/mult_bist.sv - exhaustive self-test of an array multiplier; MISR signature built only with MULT_BIST_SIG_EN
module mult_bist
    import mult_bist_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LAT   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    input  logic [2*WIDTH-1:0] prod_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [7:0]         err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic [15:0]        sig
);

    localparam int PW = 2 * WIDTH;
    localparam int DW = (LAT > 2) ? $clog2(LAT) : 1;
    localparam logic [PW-1:0] IDX_LAST = {PW{1'b1}};
    localparam logic [DW-1:0] DRAIN_LAST = DW'((LAT > 0) ? LAT - 1 : 0);

    state_t           state_q, state_d;
    logic [PW-1:0]    idx_q, idx_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [7:0]       err_q, err_d;
    logic [WIDTH-1:0] fail_a_q, fail_a_d;
    logic [WIDTH-1:0] fail_b_q, fail_b_d;

    logic             go;
    logic             mismatch;
    logic             dl_in_valid;
    logic [WIDTH-1:0] dl_in_a, dl_in_b;
    logic [PW-1:0]    dl_in_exp;
    logic             dl_out_valid;
    logic [WIDTH-1:0] dl_out_a, dl_out_b;
    logic [PW-1:0]    dl_out_exp;

    assign go          = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign dl_in_valid = (state_q == ST_RUN);
    assign dl_in_a     = idx_q[PW-1:WIDTH];
    assign dl_in_b     = idx_q[WIDTH-1:0];
    assign dl_in_exp   = PW'(dl_in_a) * PW'(dl_in_b);
    assign mismatch    = dl_out_valid && (dl_out_exp != prod_in);

    mbist_delay #(
        .WIDTH (WIDTH),
        .LAT   (LAT)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .clr       (go),
        .in_valid  (dl_in_valid),
        .in_a      (dl_in_a),
        .in_b      (dl_in_b),
        .in_exp    (dl_in_exp),
        .out_valid (dl_out_valid),
        .out_a     (dl_out_a),
        .out_b     (dl_out_b),
        .out_exp   (dl_out_exp)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        drain_d  = drain_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fail_a_d = fail_a_q;
        fail_b_d = fail_b_q;

        if (mismatch) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + 8'd1;
            end
            // A nonzero count means an earlier mismatch already owns the capture.
            if (err_q == 8'd0) begin
                fail_a_d = dl_out_a;
                fail_b_d = dl_out_b;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    state_d  = ST_RUN;
                    idx_d    = '0;
                    err_d    = '0;
                    fail_a_d = '0;
                    fail_b_d = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (idx_q == IDX_LAST) begin
                    if (LAT > 0) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end else begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 8'd0);
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 8'd0);
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            drain_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            fail_a_q <= '0;
            fail_b_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            drain_q  <= drain_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fail_a_q <= fail_a_d;
            fail_b_q <= fail_b_d;
        end
    end

`ifdef MULT_BIST_SIG_EN
    logic [15:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (go) begin
            sig_d = MISR_INIT;
        end else if (dl_out_valid) begin
            sig_d = misr_next(sig_q, 16'(prod_in));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= MISR_INIT;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`else
    assign sig = 16'h0000;
`endif

    assign a_out     = idx_q[PW-1:WIDTH];
    assign b_out     = idx_q[WIDTH-1:0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_a    = fail_a_q;
    assign fail_b    = fail_b_q;

endmodule

// File: tb/tb_mult_bist.sv
// tb/tb_mult_bist.sv - directed bench for mult_bist at LAT=0 and LAT=2; MISR checks under MULT_BIST_SIG_EN
module tb_mult_bist;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MULT_BIST_SIG_EN
    localparam logic [15:0] SIG_RST = 16'hFFFF;
`else
    localparam logic [15:0] SIG_RST = 16'h0000;
`endif

    logic       rst0, rst2, start0, start2;
    logic [3:0] a0, b0, a2, b2, fa0, fb0, fa2, fb2;
    logic [7:0] prod0, prod2, err0, err2, m1, m2;
    logic       busy0, done0, pass0, busy2, done2, pass2;
    logic [15:0] sig0, sig2;
    int         mode0;
    logic       one_stage;
    logic       sel;

    int n_checks = 0;
    int n_errors = 0;

    mult_bist #(.WIDTH(4), .LAT(0)) dut0 (
        .clk(clk), .rst(rst0), .start(start0), .a_out(a0), .b_out(b0), .prod_in(prod0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_a(fa0), .fail_b(fb0), .sig(sig0)
    );

    mult_bist #(.WIDTH(4), .LAT(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .a_out(a2), .b_out(b2), .prod_in(prod2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_a(fa2), .fail_b(fb2), .sig(sig2)
    );

    // Combinational multiplier with selectable faults for the LAT=0 instance.
    always_comb begin
        prod0 = {4'b0, a0} * {4'b0, b0};
        case (mode0)
            1: prod0[0] = 1'b0;
            2: prod0[0] = 1'b1;
            3: if (a0 == 4'd3 && b0 == 4'd5) prod0[0] = ~prod0[0];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        m1 <= {4'b0, a2} * {4'b0, b2};
        m2 <= m1;
    end
    assign prod2 = one_stage ? m1 : m2;

    wire        busy_m = sel ? busy2 : busy0;
    wire        done_m = sel ? done2 : done0;
    wire [7:0]  vec_m  = sel ? {a2, b2} : {a0, b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_sig(input int mode);
        logic [15:0] s;
        logic [7:0]  p;
        s = 16'hFFFF;
        for (int k = 0; k < 256; k++) begin
            p = 8'((k >> 4) * (k & 15));
            if (mode == 3 && k == 8'h35) p[0] = ~p[0];
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000) ^ {8'h00, p};
        end
        return s;
    endfunction

    task automatic run(input bit use2, input int mid_start, input int mid_rst, output int cycles);
        sel = use2;
        @(negedge clk);
        if (use2) start2 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start2 = 1'b0;
        check("e0_busy", busy_m, 1);
        check("e0_done", done_m, 0);
        check("e0_vec", vec_m, 0);
        cycles = 0;
        while (cycles < 1000) begin
            @(posedge clk); cycles++; #1;
            start0 = (!use2 && cycles == mid_start);
            if (done_m) break;
            if (!use2 && cycles == mid_rst) begin
                rst0 = 1'b1;
                @(posedge clk); #1;
                rst0 = 1'b0;
                check("rst_busy", busy0, 0);
                check("rst_done", done0, 0);
                check("rst_pass", pass0, 0);
                check("rst_err", err0, 0);
                check("rst_vec", {a0, b0}, 0);
                check("rst_fail", {fa0, fb0}, 0);
                check("rst_sig", sig0, SIG_RST);
                cycles = -1;
                return;
            end
        end
        if (cycles >= 1000) check("done_timeout", 0, 1);
    endtask

    int cyc;
    logic [15:0] good_sig;

    initial begin
        rst0 = 1'b1; rst2 = 1'b1; start0 = 1'b0; start2 = 1'b0;
        mode0 = 0; one_stage = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy0, 0);
        check("reset_done", done0, 0);
        check("reset_pass", pass0, 0);
        check("reset_err", err0, 0);
        check("reset_vec", {a0, b0}, 0);
        check("reset_fail", {fa0, fb0}, 0);
        check("reset_sig", sig0, SIG_RST);
        check("reset2_busy", busy2, 0);
        @(negedge clk);
        rst0 = 1'b0; rst2 = 1'b0;

        run(0, -1, -1, cyc);
        check("lat0_cycles", cyc, 256);
        check("lat0_pass", pass0, 1);
        check("lat0_err", err0, 0);
        check("lat0_fail", {fa0, fb0}, 0);
        check("lat0_busy", busy0, 0);
        check("lat0_holdvec", {a0, b0}, 8'hFF);
`ifdef MULT_BIST_SIG_EN
        good_sig = model_sig(0);
        check("sig_good", sig0, good_sig);
        repeat (3) @(posedge clk);
        #1 check("sig_stable", sig0, good_sig);
        run(0, -1, -1, cyc);
        check("sig_rerun", sig0, good_sig);
`else
        good_sig = 16'h0000;
        check("sig_tied", sig0, good_sig);
`endif

        mode0 = 1;
        run(0, -1, -1, cyc);
        check("sa0_cycles", cyc, 256);
        check("sa0_err", err0, 64);
        check("sa0_fail", {fa0, fb0}, 8'h11);
        check("sa0_pass", pass0, 0);

        mode0 = 2;
        run(0, -1, -1, cyc);
        check("sa1_err", err0, 192);
        check("sa1_fail", {fa0, fb0}, 8'h00);
        check("sa1_pass", pass0, 0);

        mode0 = 3;
        run(0, -1, -1, cyc);
        check("one_err", err0, 1);
        check("one_fail", {fa0, fb0}, 8'h35);
        check("one_pass", pass0, 0);
`ifdef MULT_BIST_SIG_EN
        check("sig_fault", sig0, model_sig(3));
        check("sig_differs", sig0 != model_sig(0), 1);
`endif

        mode0 = 0;
        run(0, 50, -1, cyc);
        check("midstart_cycles", cyc, 256);
        check("midstart_pass", pass0, 1);

        run(0, -1, 100, cyc);
        check("midrst_abort", cyc, -1);
        run(0, -1, -1, cyc);
        check("after_rst_cycles", cyc, 256);
        check("after_rst_pass", pass0, 1);

        run(1, -1, -1, cyc);
        check("lat2_cycles", cyc, 258);
        check("lat2_pass", pass2, 1);
        check("lat2_err", err2, 0);
        check("lat2_fail", {fa2, fb2}, 0);
`ifdef MULT_BIST_SIG_EN
        check("lat2_sig", sig2, good_sig);
`endif

        one_stage = 1'b1;
        run(1, -1, -1, cyc);
        check("lat2_short_cycles", cyc, 258);
        check("lat2_short_pass", pass2, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_bist.md
# mult_bist

On-chip self-test engine for the array multiplier user project. It drives the multiplier's operand inputs with every operand pair, delays the golden product to match the multiplier's pipeline latency, and compares it against the returned product. It reports a pass/fail verdict, an error count and the first failing vector. It sits between the pin-level control logic and the multiplier core, and performs on silicon the exhaustive check that the cocotb bench does in simulation.

## Interface
- `WIDTH`, 4: operand width in bits; product width is 2*WIDTH.
- `LAT`, 0: multiplier latency in cycles from operands to product (0 = combinational).
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  begin a run; sampled only in IDLE or DONE.
- `a_out`  output  WIDTH  operand A driven to the multiplier.
- `b_out`  output  WIDTH  operand B driven to the multiplier.
- `prod_in`  input  2*WIDTH  product returned by the multiplier.
- `busy`  output  1  high in RUN and DRAIN.
- `done`  output  1  high in DONE; held until the next start or reset.
- `pass`  output  1  high in DONE when `err_count` is 0; 0 in every other state.
- `err_count`  output  8  number of mismatches, saturating at 255.
- `fail_a`  output  WIDTH  operand A of the first mismatch; 0 if there is none.
- `fail_b`  output  WIDTH  operand B of the first mismatch; 0 if there is none.
- `sig`  output  16  MISR signature (see Configuration).

## Operation
- N = 2^(2*WIDTH) vectors. Index `idx` is a 2*WIDTH-bit counter; vector k is {a_out, b_out} = k, with a_out as the upper half.
- States are IDLE, RUN, DRAIN and DONE.
  - IDLE/DONE → RUN when `start`=1. This clears `idx`, `err_count`, `fail_a`/`fail_b`, `sig` and the delay line.
  - RUN: one vector per cycle. After vector N-1, go to DRAIN if LAT>0, otherwise to DONE.
  - DRAIN: lasts LAT cycles, then DONE.
  - DONE: `done`=1; `pass` = (`err_count`==0).
- `start` in RUN or DRAIN is ignored.
- Expected product = a_out*b_out at full 2*WIDTH precision. It travels with a valid bit through a LAT-stage delay line; with LAT=0 the delay line is bypassed.
- Compare happens at every edge where the delay-line output is valid.
  - On mismatch, `err_count` increments, saturating at 255.
  - On the first mismatch only, the operands carried in the delay line are captured into `fail_a`/`fail_b`.
- Reset mid-run returns to IDLE on that edge. All outputs go to 0 and the delay-line valids are cleared.
- Reset values: `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_a`=0, `fail_b`=0, `sig`=0 (0xFFFF with the macro).

## Timing
- Edge E0 samples `start`. After E0, `busy`=1 and vector 0 is on `a_out`/`b_out`.
- Vector k is driven between E_k and E_{k+1}.
- The product for vector k is sampled from `prod_in` at edge E_{k+LAT+1}.
- The last vector's product is compared at E_{N+LAT}. DONE is entered on that same edge, so `pass` is final in the first cycle `done` is high.
- Start to done latency is N+LAT cycles; for WIDTH=4, LAT=0 that is 256 cycles.
- `a_out`/`b_out` hold the last vector through DRAIN and DONE.
- Restart from DONE works the same as restart from IDLE; `done` drops after E0.

## Configuration
- `MULT_BIST_SIG_EN` defined:
  - A 16-bit Galois MISR, polynomial 0x100B, is initialised to 0xFFFF at reset and at start.
  - At every compare edge it updates: sig = (sig<<1) ^ (sig[15] ? 0x100B : 0) ^ zero-extended `prod_in`.
  - `sig` is stable in DONE.
- Undefined: no MISR logic is built; `sig` is tied to 0. The port is kept so the interface is the same in both builds.

## Structure
- Package `mult_bist_pkg`:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - `MISR_POLY` = 16'h100B;
  - `MISR_INIT` = 16'hFFFF;
  - `ERR_MAX` = 8'd255.
- Sub-module `mbist_delay`: a parameterised LAT-stage shift register carrying {valid, a, b, expected}, with synchronous clear; it passes inputs straight through when LAT=0.
- Top level holds the FSM, index counter, comparator, error counter, first-fail capture and the optional MISR.

## Test plan
- **Correct multiplier, WIDTH=4, LAT=0:** pulse `start` → `done` rises 256 cycles after E0; `pass`=1, `err_count`=0, `fail_a`=`fail_b`=0.
- **LAT=2, multiplier registered twice:** same stimulus → `done` 258 cycles after E0; `pass`=1. A 1-stage multiplier with LAT=2 → `pass`=0.
- **prod_in[0] stuck-at-0, LAT=0:** → `err_count`=64, `fail_a`=1, `fail_b`=1, `pass`=0.
- **prod_in[0] stuck-at-1:** → `err_count`=192, `fail_a`=0, `fail_b`=0.
- **Mid-run events:**
  - Pulse `start` at vector 50 → ignored; completion timing is unchanged.
  - Assert `rst` at vector 100 → next cycle all outputs are 0 and state is IDLE; a following `start` completes normally.
- **With `MULT_BIST_SIG_EN`:** two runs with a correct multiplier → identical `sig`. A run with one faulty vector → different `sig`.
